// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD result display: segment glyphs and scan geometry.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package bcd_disp_pkg;

    localparam int IDX_W      = 2;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan position to displayed quantity.
    typedef enum logic [IDX_W-1:0] {
        DIG_SUM  = 2'd0,
        DIG_COUT = 2'd1,
        DIG_B    = 2'd2,
        DIG_A    = 2'd3
    } digit_sel_t;

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-BCD codes (10..15) render as 'E'; blank overrides everything.
module bcd_seg_decoder
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_result_display.sv
// Captures BCD adder operands/result and scans them onto a 4-digit multiplexed
// active-low 7-segment display; all outputs are registered.
module bcd_result_display
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [3:0]            a_i,
    input  logic [3:0]            b_i,
    input  logic [3:0]            sum_i,
    input  logic                  cout_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic                  err_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            a_cap;
    logic [3:0]            b_cap;
    logic [3:0]            sum_cap;
    logic                  cout_cap;

    digit_sel_t            sel;
    logic [3:0]            digit;
    logic                  blank;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  dp_next;

    // Prescaler and scan index; independent of capture activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cap    <= '0;
            b_cap    <= '0;
            sum_cap  <= '0;
            cout_cap <= 1'b0;
            err_o    <= 1'b0;
        end else if (load_i) begin
            a_cap    <= a_i;
            b_cap    <= b_i;
            sum_cap  <= sum_i;
            cout_cap <= cout_i;
            err_o    <= (a_i > 4'd9) | (b_i > 4'd9) | (sum_i > 4'd9);
        end
    end

    always_comb begin
        sel     = digit_sel_t'(idx);
        digit   = 4'd0;
        blank   = 1'b0;
        dp_next = 1'b1;
        case (sel)
            DIG_SUM:  digit = sum_cap;
            DIG_COUT: begin
                digit = {3'b000, cout_cap};
                blank = BLANK_LZ && !cout_cap;
            end
            DIG_B: begin
                digit   = b_cap;
                dp_next = 1'b0;
            end
            DIG_A:    digit = a_cap;
            default:  digit = 4'd0;
        endcase
        an_next = ~(NUM_DIGITS'(1) << idx);
    end

    bcd_seg_decoder u_dec (
        .digit (digit),
        .blank (blank),
        .seg   (seg_next)
    );

    // Output stage: one cycle behind idx and the capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_o  <= '1;
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= an_next;
            seg_o <= seg_next;
            dp_o  <= dp_next;
        end
    end

endmodule

// File: tb/tb_bcd_result_display.sv
// Bench for bcd_result_display: three instances (div 4 blanking, div 4 no blanking,
// div 1) share stimulus and are compared to an edge-count based reference model.
module tb_bcd_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic [3:0] s_in = '0;
    logic       c_in = 1'b0;

    logic [6:0] seg4, segnb, seg1;
    logic       dp4, dpnb, dp1;
    logic [3:0] an4, annb, an1;
    logic       err4, errnb, err1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: edges since reset release plus captured values.
    int         n = 0;
    logic [3:0] ma = '0, mb = '0, ms = '0;
    logic       mc = 1'b0, merr = 1'b0;

    always #5 clk = ~clk;

    bcd_result_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .load_i(load), .a_i(a_in), .b_i(b_in), .sum_i(s_in),
        .cout_i(c_in), .seg_o(seg4), .dp_o(dp4), .an_o(an4), .err_o(err4));

    bcd_result_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .load_i(load), .a_i(a_in), .b_i(b_in), .sum_i(s_in),
        .cout_i(c_in), .seg_o(segnb), .dp_o(dpnb), .an_o(annb), .err_o(errnb));

    bcd_result_display #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .load_i(load), .a_i(a_in), .b_i(b_in), .sum_i(s_in),
        .cout_i(c_in), .seg_o(seg1), .dp_o(dp1), .an_o(an1), .err_o(err1));

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    // Display {an, seg, dp} produced at edge number cyc for a given divider.
    function automatic logic [11:0] exp_disp(input int cyc, input int div, input bit blz);
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        k = (cyc / div) % 4;
        an = 4'hF;
        an[k] = 1'b0;
        case (k)
            0: seg = glyph(ms);
            1: seg = (blz && !mc) ? 7'h7F : glyph({3'b000, mc});
            2: seg = glyph(mb);
            default: seg = glyph(ma);
        endcase
        return {an, seg, (k == 2) ? 1'b0 : 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, n);
        end
    endtask

    task automatic step(input bit ld, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic c);
        logic [11:0] e4, enb, e1;
        load = ld; a_in = a; b_in = b; s_in = s; c_in = c;
        @(posedge clk);
        e4  = exp_disp(n, 4, 1'b1);
        enb = exp_disp(n, 4, 1'b0);
        e1  = exp_disp(n, 1, 1'b1);
        if (ld) begin
            ma = a; mb = b; ms = s; mc = c;
            merr = (a > 9) || (b > 9) || (s > 9);
        end
        n++;
        #1;
        chk("disp_div4",  {an4, seg4, dp4},    e4);
        chk("disp_nolz",  {annb, segnb, dpnb}, enb);
        chk("disp_div1",  {an1, seg1, dp1},    e1);
        chk("err",        {11'd0, err4},       {11'd0, merr});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    // Reset asserted between edges must act immediately.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_div4", {an4, seg4, dp4},    {4'hF, 7'h7F, 1'b1});
        chk("rst_nolz", {annb, segnb, dpnb}, {4'hF, 7'h7F, 1'b1});
        chk("rst_div1", {an1, seg1, dp1},    {4'hF, 7'h7F, 1'b1});
        chk("rst_err",  {9'd0, err4, errnb, err1}, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0; ma = '0; mb = '0; ms = '0; mc = 1'b0; merr = 1'b0;
    endtask

    initial begin
        load = 1'b0;
        apply_reset();
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("first_edge", {an4, seg4, dp4}, {4'b1110, 7'h40, 1'b1});
        idle(5);
        step(1'b1, 4'd7, 4'd5, 4'd2, 1'b1);
        idle(6);
        apply_reset();
        step(1'b1, 4'd7, 4'd5, 4'd2, 1'b1);
        idle(20);
        step(1'b1, 4'd3, 4'd4, 4'd7, 1'b0);
        idle(16);
        step(1'b1, 4'd3, 4'd4, 4'd12, 1'b0);
        chk("err_set", {11'd0, err4}, 12'd1);
        idle(16);
        step(1'b1, 4'd1, 4'd1, 4'd2, 1'b0);
        chk("err_clr", {11'd0, err4}, 12'd0);
        step(1'b1, 4'd15, 4'd9, 4'd9, 1'b1);
        step(1'b1, 4'd2, 4'd6, 4'd8, 1'b0);
        idle(4);
        while ((n % 16) != 15) idle(1);
        step(1'b1, 4'd1, 4'd2, 4'd9, 1'b1);
        idle(20);
        for (int i = 0; i < 300; i++) begin
            if (i == 150) apply_reset();
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
